// File: rtl/pipearch_pkg.sv
// pipearch_pkg: shared FP32 types and the behavioural FP32 multiply used by the vector multiplier
// Contents:
//   FP32_W, fp32_t, FP32_ZERO, FP32_QNAN
//   fp32_mul(a, b): IEEE-754 single multiply, round-nearest-even, subnormal inputs/outputs flushed to zero
package pipearch_pkg;

    localparam int FP32_W = 32;
    typedef logic [FP32_W-1:0] fp32_t;
    localparam fp32_t FP32_ZERO = 32'h0000_0000;
    localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

    function automatic fp32_t fp32_mul(fp32_t a, fp32_t b);
        logic              s;
        logic [7:0]        ea, eb;
        logic [47:0]       p;
        logic [24:0]       m;
        logic              g, st;
        logic signed [9:0] e;
        logic              nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
        fp32_t             r;
        s      = a[31] ^ b[31];
        ea     = a[30:23];
        eb     = b[30:23];
        nan_a  = (ea == 8'hFF) && (a[22:0] != 23'h0);
        nan_b  = (eb == 8'hFF) && (b[22:0] != 23'h0);
        inf_a  = (ea == 8'hFF) && (a[22:0] == 23'h0);
        inf_b  = (eb == 8'hFF) && (b[22:0] == 23'h0);
        zero_a = (ea == 8'h00);
        zero_b = (eb == 8'h00);
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        // Product of two 1.x mantissas lies in [1,4); normalise to 1.x before rounding
        if (p[47]) begin
            m  = {1'b0, p[47:24]};
            g  = p[23];
            st = |p[22:0];
            e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd126;
        end else begin
            m  = {1'b0, p[46:23]};
            g  = p[22];
            st = |p[21:0];
            e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
        end
        m = m + 25'(g & (st | m[0]));
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a))
            r = FP32_QNAN;
        else if (inf_a | inf_b)
            r = {s, 8'hFF, 23'h0};
        else if (zero_a | zero_b)
            r = {s, 31'h0};
        else if (e >= 10'sd255)
            r = {s, 8'hFF, 23'h0};
        else if (e <= 10'sd0)
            r = {s, 31'h0};
        else
            r = {s, e[7:0], 23'(m)};
        return r;
    endfunction

endpackage

// File: rtl/float_mult_vec_result_fifo.sv
// result_fifo: synchronous first-word-fall-through FIFO with registered outputs
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   push, push_data      write one entry (caller guarantees space)
//   ready                consumer takes the head when out_valid is high
//   out_valid, out_data  registered head entry
// The output register counts as one of the DEPTH entries; mem holds the rest.
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic             take, mem_wr, mem_rd, full;

    // take: output register is free to load this cycle
    assign take   = ~out_valid | ready;
    assign mem_rd = take & (mem_cnt != '0);
    // an arriving entry bypasses mem straight into an empty output register
    assign mem_wr = push & ~(take & (mem_cnt == '0));
    assign full   = (mem_cnt + CW'(out_valid)) == CW'(DEPTH);

    function automatic logic [PW-1:0] nxt(logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (mem_wr)
                wr_ptr <= nxt(wr_ptr);
            if (mem_rd)
                rd_ptr <= nxt(rd_ptr);
            mem_cnt <= mem_cnt + CW'(mem_wr) - CW'(mem_rd);
            if (take)
                out_valid <= (mem_cnt != '0) | push;
            if (mem_rd)
                out_data <= mem[rd_ptr];
            else if (take & push)
                out_data <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_wr)
            mem[wr_ptr] <= push_data;
    end

    always @(posedge clk) begin
        if (!reset)
            assert (!(push && full && !(out_valid && ready)));
    end

endmodule

// File: rtl/float_mult_vec.sv
// float_mult_vec: LANES-wide FP32 multiplier with valid/ready flow control, lane mask and scalar broadcast
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_ready          input handshake; in_ready is registered (credits != 0)
//   in1, in2                   operands, lane i = bits [32i+31:32i]
//   in_broadcast               1: every lane uses in2 lane 0 as operand B
//   in_mask                    0 = lane result forced to +0.0
//   in_tag, in_last            sideband returned with the result
//   q_valid/q_ready            output handshake
//   q, q_tag, q_last           products and sideband, held until accepted
// The cores cannot stall, so a credit per FIFO slot is taken on issue and returned on pop;
// every beat in flight therefore always has a FIFO entry waiting for it.
module float_mult_vec
    import pipearch_pkg::*;
#(
    parameter int LANES        = 8,
    parameter int MULT_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8,
    parameter int TAG_W        = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FP32_W*LANES-1:0] in1,
    input  logic [FP32_W*LANES-1:0] in2,
    input  logic                    in_broadcast,
    input  logic [LANES-1:0]        in_mask,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    in_last,
    output logic                    q_valid,
    input  logic                    q_ready,
    output logic [FP32_W*LANES-1:0] q,
    output logic [TAG_W-1:0]        q_tag,
    output logic                    q_last
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int EW = FP32_W * LANES + TAG_W + 1;

    logic [CW-1:0]           credits, credits_next;
    logic                    ready_r, issue, pop;
    logic                    vld     [MULT_LATENCY];
    logic [TAG_W-1:0]        tag_sr  [MULT_LATENCY];
    logic                    last_sr [MULT_LATENCY];
    logic [FP32_W*LANES-1:0] prod;
    logic [EW-1:0]           entry;

    assign in_ready     = ready_r;
    assign issue        = in_valid & ready_r;
    assign pop          = q_valid & q_ready;
    assign credits_next = credits - CW'(issue) + CW'(pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credits <= CW'(FIFO_DEPTH);
            ready_r <= 1'b0;
        end else begin
            credits <= credits_next;
            ready_r <= credits_next != '0;
        end
    end

    // Only the valid bits need reset: stale core data behind a cleared valid is never pushed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < MULT_LATENCY; k++)
                vld[k] <= 1'b0;
        end else begin
            vld[0] <= issue;
            for (int k = 1; k < MULT_LATENCY; k++)
                vld[k] <= vld[k-1];
        end
    end

    always_ff @(posedge clk) begin
        tag_sr[0]  <= in_tag;
        last_sr[0] <= in_last;
        for (int k = 1; k < MULT_LATENCY; k++) begin
            tag_sr[k]  <= tag_sr[k-1];
            last_sr[k] <= last_sr[k-1];
        end
    end

    genvar i;
    for (i = 0; i < LANES; i++) begin : g_lane
        fp32_t a, b;
        // masked lanes compute 0*0 so the result is exactly +0.0
        assign a = in_mask[i] ? in1[FP32_W*i +: FP32_W] : FP32_ZERO;
        assign b = in_mask[i] ? (in_broadcast ? in2[FP32_W-1:0] : in2[FP32_W*i +: FP32_W]) : FP32_ZERO;
`ifdef XILINX
        fp32_mult_xilinx u_core (.clk(clk), .a(a), .b(b), .p(prod[FP32_W*i +: FP32_W]));
`elsif ARRIA10
        fp32_mult_arria10 u_core (.clk(clk), .a(a), .b(b), .p(prod[FP32_W*i +: FP32_W]));
`else
        fp32_t pipe [MULT_LATENCY];
        always_ff @(posedge clk) begin
            pipe[0] <= fp32_mul(a, b);
            for (int k = 1; k < MULT_LATENCY; k++)
                pipe[k] <= pipe[k-1];
        end
        assign prod[FP32_W*i +: FP32_W] = pipe[MULT_LATENCY-1];
`endif
    end

    result_fifo #(
        .WIDTH(EW),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (vld[MULT_LATENCY-1]),
        .push_data({tag_sr[MULT_LATENCY-1], last_sr[MULT_LATENCY-1], prod}),
        .ready    (q_ready),
        .out_valid(q_valid),
        .out_data (entry)
    );

    assign {q_tag, q_last, q} = entry;

endmodule

// File: tb/tb_float_mult_vec.sv
// tb_float_mult_vec: directed and random checks of float_mult_vec against a real-arithmetic reference
module tb_float_mult_vec;

    localparam int LANES = 8;
    localparam int LAT   = 3;
    localparam int TW    = 8;
    localparam int DW    = 32 * LANES;
    localparam int W     = DW + TW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in1 = '0;
    logic [DW-1:0] in2 = '0;
    logic          in_broadcast = 1'b0;
    logic [7:0]    in_mask = 8'hFF;
    logic [TW-1:0] in_tag = '0;
    logic          in_last = 1'b0;
    logic          q_ready = 1'b1;

    logic          rdy_a, qv_a, q_last_a, rdy_b, qv_b, q_last_b;
    logic [DW-1:0] q_a, q_b;
    logic [TW-1:0] q_tag_a, q_tag_b;

    int checks = 0;
    int errors = 0;
    int pops_b = 0;
    logic last_b = 1'b0;
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];

    always #5 clk = ~clk;

    float_mult_vec #(.LANES(LANES), .MULT_LATENCY(LAT), .FIFO_DEPTH(8), .TAG_W(TW)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a), .in1(in1), .in2(in2),
        .in_broadcast(in_broadcast), .in_mask(in_mask), .in_tag(in_tag), .in_last(in_last),
        .q_valid(qv_a), .q_ready(q_ready), .q(q_a), .q_tag(q_tag_a), .q_last(q_last_a));

    float_mult_vec #(.LANES(LANES), .MULT_LATENCY(LAT), .FIFO_DEPTH(LAT + 2), .TAG_W(TW)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b), .in1(in1), .in2(in2),
        .in_broadcast(in_broadcast), .in_mask(in_mask), .in_tag(in_tag), .in_last(in_last),
        .q_valid(qv_b), .q_ready(q_ready), .q(q_b), .q_tag(q_tag_b), .q_last(q_last_b));

    task automatic chk(string tag, logic [279:0] obs, logic [279:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic real to_real(logic [31:0] a);
        return $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'b0});
    endfunction

    // Exact product in double precision, then one IEEE rounding step down to single
    function automatic logic [31:0] ref_mul(logic [31:0] a, logic [31:0] b);
        logic        s;
        int          ea, eb, e;
        logic [63:0] d;
        logic [28:0] rest;
        logic [23:0] f;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0) ||
            (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
            return 32'h7FC00000;
        if (ea == 255 || eb == 255)
            return {s, 8'hFF, 23'h0};
        if (ea == 0 || eb == 0)
            return {s, 31'h0};
        d    = $realtobits(to_real(a) * to_real(b));
        e    = int'(d[62:52]) - 896;
        rest = d[28:0];
        f    = {1'b0, d[51:29]};
        if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && d[29]))
            f = f + 24'd1;
        if (f[23]) begin
            f = 24'd0;
            e++;
        end
        if (e >= 255)
            return {s, 8'hFF, 23'h0};
        if (e <= 0)
            return {s, 31'h0};
        return {s, 8'(e), f[22:0]};
    endfunction

    function automatic logic [DW-1:0] exp_vec();
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++)
            r[32*i +: 32] = !in_mask[i] ? 32'h0 :
                            ref_mul(in1[32*i +: 32], in_broadcast ? in2[31:0] : in2[32*i +: 32]);
        return r;
    endfunction

    function automatic logic [31:0] rnd_fp();
        if ($urandom_range(0, 15) == 0)
            return $urandom;
        return {1'($urandom), 8'($urandom_range(60, 194)), 23'($urandom)};
    endfunction

    task automatic rnd_inputs();
        for (int i = 0; i < LANES; i++) begin
            in1[32*i +: 32] = rnd_fp();
            in2[32*i +: 32] = rnd_fp();
        end
        in_mask      = 8'($urandom);
        in_broadcast = ($urandom_range(0, 3) == 0);
    endtask

    // Called at a negedge with inputs set: record accepts, check pops, advance one cycle
    task automatic tick();
        logic [W-1:0] e;
        if (in_valid && rdy_a)
            qa.push_back({in_tag, in_last, exp_vec()});
        if (in_valid && rdy_b)
            qb.push_back({in_tag, in_last, exp_vec()});
        if (qv_a && q_ready) begin
            chk("pop_a_expected", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                chk("result_a", {q_tag_a, q_last_a, q_a}, e);
            end
        end
        if (qv_b && q_ready) begin
            pops_b++;
            last_b = q_last_b;
            chk("pop_b_expected", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                chk("result_b", {q_tag_b, q_last_b, q_b}, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_wait(output int n);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 1;
        while (!qv_a && n < 20) begin
            tick();
            n++;
        end
        chk("wait_q_valid", qv_a, 1);
    endtask

    initial begin
        int n, acc_a, acc_b, k, drops, p0, spurious;
        logic was_a, was_b;

        #1 reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_q_valid", qv_a, 0);
        chk("reset_q", q_a, 0);
        chk("reset_q_tag", q_tag_a, 0);
        chk("reset_q_last", q_last_a, 0);
        chk("reset_in_ready", rdy_a, 0);
        reset = 1'b0;
        tick();
        chk("ready_after_reset_a", rdy_a, 1);
        chk("ready_after_reset_b", rdy_b, 1);

        // single beat 2.0 * 3.0
        for (int i = 0; i < LANES; i++) begin
            in1[32*i +: 32] = 32'h40000000;
            in2[32*i +: 32] = 32'h40400000;
        end
        in_mask = 8'hFF;
        in_tag  = 8'h5A;
        send_wait(n);
        chk("single_latency", n, LAT + 1);
        chk("single_q", q_a, {8{32'h40C00000}});
        chk("single_tag", q_tag_a, 8'h5A);
        tick();

        // broadcast of in2 lane 0 = 0.5
        in1[127:0] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        for (int i = 4; i < LANES; i++)
            in1[32*i +: 32] = rnd_fp();
        for (int i = 0; i < LANES; i++)
            in2[32*i +: 32] = (i == 0) ? 32'h3F000000 : 32'h40E00000;
        in_broadcast = 1'b1;
        in_tag       = 8'h11;
        send_wait(n);
        chk("bcast_lanes0_3", q_a[127:0], {32'h40000000, 32'h3FC00000, 32'h3F800000, 32'h3F000000});
        tick();
        in_broadcast = 1'b0;

        // mask 0x0F with 1.5 * 2.0
        for (int i = 0; i < LANES; i++) begin
            in1[32*i +: 32] = 32'h3FC00000;
            in2[32*i +: 32] = 32'h40000000;
        end
        in_mask = 8'h0F;
        in_tag  = 8'h22;
        send_wait(n);
        chk("mask_q", q_a, {{4{32'h0}}, {4{32'h40400000}}});
        tick();

        // backpressure: FIFO_DEPTH beats accepted, then in_ready low
        q_ready  = 1'b0;
        in_valid = 1'b1;
        acc_a    = 0;
        for (int i = 0; i < 20; i++) begin
            rnd_inputs();
            in_tag = 8'(acc_a);
            was_a  = rdy_a;
            tick();
            if (was_a)
                acc_a++;
        end
        chk("bp_accepted", acc_a, 8);
        chk("bp_ready_low", rdy_a, 0);
        in_valid = 1'b0;
        q_ready  = 1'b1;
        k = 0;
        for (int i = 0; i < 30; i++) begin
            if (qv_a) begin
                chk("drain_tag_order", q_tag_a, k);
                k++;
            end
            tick();
        end
        chk("drain_count", k, 8);

        // streaming 100 beats through the minimum-depth instance
        p0    = pops_b;
        drops = 0;
        for (int i = 0; i < 100; i++) begin
            rnd_inputs();
            in_tag   = 8'(i);
            in_last  = (i == 99);
            in_valid = 1'b1;
            if (!rdy_b)
                drops++;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int i = 0; i < 30 && (qa.size() != 0 || qb.size() != 0); i++)
            tick();
        chk("stream_ready_drops", drops, 0);
        chk("stream_count", pops_b - p0, 100);
        chk("stream_last_flag", last_b, 1);

        // reset with beats in flight
        acc_a = 0;
        for (int i = 0; i < 10 && acc_a < 4; i++) begin
            rnd_inputs();
            in_valid = 1'b1;
            was_a    = rdy_a;
            tick();
            if (was_a)
                acc_a++;
        end
        in_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk("midreset_q_valid", qv_a, 0);
        chk("midreset_in_ready", rdy_a, 0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        spurious = 0;
        for (int i = 0; i < 10; i++) begin
            if (qv_a || qv_b)
                spurious++;
            tick();
        end
        chk("no_spurious_valid", spurious, 0);
        q_ready  = 1'b0;
        in_valid = 1'b1;
        acc_a    = 0;
        acc_b    = 0;
        for (int i = 0; i < 12; i++) begin
            rnd_inputs();
            in_tag = 8'(i + 100);
            was_a  = rdy_a;
            was_b  = rdy_b;
            tick();
            if (was_a)
                acc_a++;
            if (was_b)
                acc_b++;
        end
        chk("credits_restored_a", acc_a, 8);
        chk("credits_restored_b", acc_b, LAT + 2);
        in_valid = 1'b0;
        q_ready  = 1'b1;
        for (int i = 0; i < 30; i++)
            tick();
        chk("final_empty_a", qa.size(), 0);
        chk("final_empty_b", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
